// File: rtl/mips_register_scoreboard_registers.sv
// Multi-port GPR file with per-register pending bits for the dual-issue pipeline.
// Reads bypass same-cycle writes; the issue port stalls on WAW hazards.
package mips_register_scoreboard_registers_pkg;
  typedef struct packed {
    logic clk_sys;
    logic rst_b;
  } Data_Control_T;
endpackage

module mips_register_scoreboard_registers
  import mips_register_scoreboard_registers_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_L   = 32,
  parameter int                ADDR_W   = $clog2(ADDR_L),
  parameter int                RD_PORTS = 2,
  parameter int                WR_PORTS = 2,
  parameter logic [DATA_W-1:0] RESET    = '0,
  parameter bit                ZERO_REG = 1'b1,
  parameter int                CNT_W    = $clog2(ADDR_L) + 1
) (
  input  Data_Control_T                 ctrl,
  input  logic [RD_PORTS*ADDR_W-1:0]    rdAddr,
  output logic [RD_PORTS*DATA_W-1:0]    rdData,
  output logic [RD_PORTS-1:0]           rdReady,
  input  logic [WR_PORTS*ADDR_W-1:0]    wrAddr,
  input  logic [WR_PORTS*DATA_W-1:0]    wrData,
  input  logic [WR_PORTS-1:0]           wrEnable,
  input  logic [ADDR_W-1:0]             issAddr,
  input  logic                          issEnable,
  output logic                          issStall,
  output logic [CNT_W-1:0]              pendCount
);

  logic [DATA_W-1:0]   regs [ADDR_L];
  logic [ADDR_L-1:0]   pend;
  logic [ADDR_L-1:0]   pend_next;
  logic [ADDR_L-1:0]   wr_hit;
  logic [WR_PORTS-1:0] wr_eff;
  logic                iss_acc;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    cnt_dec;

  always_comb begin
    wr_eff = '0;
    wr_hit = '0;
    for (int w = 0; w < WR_PORTS; w++) begin
      wr_eff[w] = wrEnable[w] && !(ZERO_REG && (wrAddr[w*ADDR_W +: ADDR_W] == '0));
      if (wr_eff[w]) wr_hit[wrAddr[w*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // Later write ports overwrite earlier matches, so the highest index wins the bypass.
  always_comb begin
    rdData  = '0;
    rdReady = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rdData[p*DATA_W +: DATA_W] = regs[rdAddr[p*ADDR_W +: ADDR_W]];
      rdReady[p]                 = !pend[rdAddr[p*ADDR_W +: ADDR_W]];
      for (int w = 0; w < WR_PORTS; w++) begin
        if (wr_eff[w] && (wrAddr[w*ADDR_W +: ADDR_W] == rdAddr[p*ADDR_W +: ADDR_W])) begin
          rdData[p*DATA_W +: DATA_W] = wrData[w*DATA_W +: DATA_W];
          rdReady[p]                 = 1'b1;
        end
      end
      if (ZERO_REG && (rdAddr[p*ADDR_W +: ADDR_W] == '0)) begin
        rdData[p*DATA_W +: DATA_W] = '0;
        rdReady[p]                 = 1'b1;
      end
    end
  end

  assign issStall = issEnable && pend[issAddr] && !wr_hit[issAddr];
  assign iss_acc  = issEnable && !issStall && !(ZERO_REG && (issAddr == '0));

  // A new producer supersedes a completing write to the same register.
  always_comb begin
    pend_next = pend & ~wr_hit;
    if (iss_acc) pend_next[issAddr] = 1'b1;
  end

  always_comb begin
    cnt_dec = '0;
    for (int r = 0; r < ADDR_L; r++) begin
      cnt_dec = cnt_dec + CNT_W'(pend[r] & wr_hit[r]);
    end
  end

  assign cnt_inc = CNT_W'(iss_acc);

  always_ff @(posedge ctrl.clk_sys) begin
    if (!ctrl.rst_b) begin
      for (int r = 0; r < ADDR_L; r++) regs[r] <= RESET;
      pend      <= '0;
      pendCount <= '0;
    end else begin
      for (int w = 0; w < WR_PORTS; w++) begin
        if (wr_eff[w]) regs[wrAddr[w*ADDR_W +: ADDR_W]] <= wrData[w*DATA_W +: DATA_W];
      end
      pend      <= pend_next;
      pendCount <= pendCount + cnt_inc - cnt_dec;
    end
  end

endmodule

// File: tb/tb_mips_register_scoreboard_registers.sv
// Bench for the scoreboarded register file: directed scenarios with literal
// expectations plus a randomized run compared every cycle against an array model.
module tb_mips_register_scoreboard_registers;
  import mips_register_scoreboard_registers_pkg::*;

  localparam logic [31:0] RST_VAL = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  Data_Control_T ctrl;
  logic [9:0]    rdAddr;
  logic [63:0]   rdData;
  logic [1:0]    rdReady;
  logic [9:0]    wrAddr;
  logic [63:0]   wrData;
  logic [1:0]    wrEnable;
  logic [4:0]    issAddr;
  logic          issEnable;
  logic          issStall;
  logic [5:0]    pendCount;

  int n_checks = 0;
  int n_fail   = 0;

  assign ctrl = '{clk_sys: clk, rst_b: rst_b};

  always #5 clk = ~clk;

  mips_register_scoreboard_registers #(
    .DATA_W(32), .ADDR_L(32), .ADDR_W(5), .RD_PORTS(2), .WR_PORTS(2),
    .RESET(RST_VAL), .ZERO_REG(1'b1), .CNT_W(6)
  ) dut (
    .ctrl(ctrl), .rdAddr(rdAddr), .rdData(rdData), .rdReady(rdReady),
    .wrAddr(wrAddr), .wrData(wrData), .wrEnable(wrEnable),
    .issAddr(issAddr), .issEnable(issEnable), .issStall(issStall),
    .pendCount(pendCount)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural register contents and pending marks.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  logic [31:0] nx_regs [32];
  bit          nx_pend [32];
  bit          model_valid = 1'b0;
  bit          c_hit [32];
  logic [31:0] c_val [32];
  logic [63:0] e_data;
  logic [1:0]  e_rdy;
  bit          e_stall;
  bit          e_acc;
  int          e_cnt;

  always @(negedge clk) begin
    for (int r = 0; r < 32; r++) begin
      c_hit[r] = 1'b0;
      c_val[r] = '0;
    end
    for (int w = 0; w < 2; w++) begin
      if (wrEnable[w] && wrAddr[w*5 +: 5] != 5'd0) begin
        c_hit[wrAddr[w*5 +: 5]] = 1'b1;
        c_val[wrAddr[w*5 +: 5]] = wrData[w*32 +: 32];
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (rdAddr[p*5 +: 5] == 5'd0) begin
        e_data[p*32 +: 32] = 32'd0;
        e_rdy[p] = 1'b1;
      end else if (c_hit[rdAddr[p*5 +: 5]]) begin
        e_data[p*32 +: 32] = c_val[rdAddr[p*5 +: 5]];
        e_rdy[p] = 1'b1;
      end else begin
        e_data[p*32 +: 32] = m_regs[rdAddr[p*5 +: 5]];
        e_rdy[p] = !m_pend[rdAddr[p*5 +: 5]];
      end
    end
    e_stall = issEnable && m_pend[issAddr] && !c_hit[issAddr];
    e_acc   = issEnable && !e_stall && (issAddr != 5'd0);
    e_cnt   = 0;
    for (int r = 0; r < 32; r++) e_cnt += int'(m_pend[r]);
    if (model_valid) begin
      check("rdData", rdData, e_data);
      check("rdReady", 64'(rdReady), 64'(e_rdy));
      check("issStall", 64'(issStall), 64'(e_stall));
      check("pendCount", 64'(pendCount), 64'(e_cnt));
    end
    for (int r = 0; r < 32; r++) begin
      nx_regs[r] = c_hit[r] ? c_val[r] : m_regs[r];
      nx_pend[r] = m_pend[r] && !c_hit[r];
    end
    if (e_acc) nx_pend[issAddr] = 1'b1;
  end

  always @(posedge clk) begin
    if (!rst_b) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = RST_VAL;
        m_pend[r] = 1'b0;
      end
      model_valid = 1'b1;
    end else if (model_valid) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = nx_regs[r];
        m_pend[r] = nx_pend[r];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrEnable  = 2'b00;
    issEnable = 1'b0;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rdAddr = '0; wrAddr = '0; wrData = '0; wrEnable = '0;
    issAddr = '0; issEnable = 1'b0; rst_b = 1'b0;
    tick();
    rst_b = 1'b1;

    // Reset values
    rdAddr = {5'd0, 5'd5};
    @(negedge clk);
    check("t1_r5", 64'(rdData[31:0]), 64'h0000_0000_DEAD_BEEF);
    check("t1_r0", 64'(rdData[63:32]), 64'h0);
    check("t1_rdy", 64'(rdReady), 64'h3);
    check("t1_cnt", 64'(pendCount), 64'h0);
    tick();

    // Same-address write priority and bypass
    wrAddr = {5'd7, 5'd7}; wrData = {32'h22, 32'h11}; wrEnable = 2'b11;
    rdAddr = {5'd0, 5'd7};
    @(negedge clk);
    check("t2_bypass", 64'(rdData[31:0]), 64'h22);
    tick();
    idle();
    @(negedge clk);
    check("t2_stored", 64'(rdData[31:0]), 64'h22);
    tick();

    // RAW readiness
    issAddr = 5'd9; issEnable = 1'b1;
    tick();
    idle();
    rdAddr = {5'd0, 5'd9};
    @(negedge clk);
    check("t3_notready", 64'(rdReady[0]), 64'h0);
    check("t3_cnt1", 64'(pendCount), 64'h1);
    tick();
    wrAddr = {5'd0, 5'd9}; wrData = {32'h0, 32'h5A}; wrEnable = 2'b01;
    @(negedge clk);
    check("t3_bypass", 64'(rdData[31:0]), 64'h5A);
    check("t3_ready", 64'(rdReady[0]), 64'h1);
    tick();
    idle();
    @(negedge clk);
    check("t3_cnt0", 64'(pendCount), 64'h0);
    tick();

    // WAW stall
    issAddr = 5'd3; issEnable = 1'b1;
    tick();
    @(negedge clk);
    check("t4_stall", 64'(issStall), 64'h1);
    tick();
    wrAddr = {5'd0, 5'd3}; wrData = {32'h0, 32'h33}; wrEnable = 2'b01;
    @(negedge clk);
    check("t4_cnt_after_stall", 64'(pendCount), 64'h1);
    check("t4_nostall", 64'(issStall), 64'h0);
    tick();
    idle();
    rdAddr = {5'd0, 5'd3};
    @(negedge clk);
    check("t4_cnt_kept", 64'(pendCount), 64'h1);
    check("t4_still_pend", 64'(rdReady[0]), 64'h0);
    tick();
    wrEnable = 2'b01;
    tick();
    idle();
    @(negedge clk);
    check("t4_cleared", 64'(pendCount), 64'h0);
    tick();

    // Zero register
    wrAddr = '0; wrData = {32'h0, 32'hFF}; wrEnable = 2'b01;
    issAddr = 5'd0; issEnable = 1'b1; rdAddr = '0;
    @(negedge clk);
    check("t5_r0_bypass", 64'(rdData[31:0]), 64'h0);
    check("t5_r0_ready", 64'(rdReady[0]), 64'h1);
    check("t5_r0_nostall", 64'(issStall), 64'h0);
    tick();
    idle();
    @(negedge clk);
    check("t5_r0_after", 64'(rdData[31:0]), 64'h0);
    check("t5_cnt", 64'(pendCount), 64'h0);
    tick();

    // Count and mid-operation reset
    issAddr = 5'd1; issEnable = 1'b1;
    tick();
    issAddr = 5'd2;
    tick();
    issAddr = 5'd4;
    tick();
    idle();
    @(negedge clk);
    check("t6_cnt3", 64'(pendCount), 64'h3);
    tick();
    wrAddr = {5'd1, 5'd1}; wrData = {32'hA1, 32'hB1}; wrEnable = 2'b11;
    tick();
    idle();
    @(negedge clk);
    check("t6_cnt2", 64'(pendCount), 64'h2);
    tick();
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    rdAddr = {5'd4, 5'd2};
    @(negedge clk);
    check("t6_rst_cnt", 64'(pendCount), 64'h0);
    check("t6_rst_rdy", 64'(rdReady), 64'h3);
    check("t6_rst_data", rdData, {RST_VAL, RST_VAL});
    tick();

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      rst_b     = ($urandom_range(0, 149) != 0);
      rdAddr    = {rnd_addr(), rnd_addr()};
      wrAddr    = {rnd_addr(), rnd_addr()};
      wrData    = {$urandom, $urandom};
      wrEnable  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      issAddr   = rnd_addr();
      issEnable = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst_b = 1'b1;
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_register_scoreboard_registers.md
# mips_register_scoreboard_registers

Multi-port MIPS general-purpose register file with per-register pending (scoreboard) bits, for the dual-issue pipeline. Provides `RD_PORTS` combinational read ports with write-through bypass, `WR_PORTS` prioritised write ports, and one issue port that marks a destination register as awaiting a result. Read ports report data readiness, so decode can stall on RAW hazards. The issue port stalls on WAW hazards.

## Interface
- `DATA_W`, 32: register width.
- `ADDR_L`, 32: number of registers.
- `ADDR_W`, `Util_Math_log2(ADDR_L)`: register address width.
- `RD_PORTS`, 2: number of read ports (≥1).
- `WR_PORTS`, 2: number of write ports (≥1).
- `RESET`, `DATA_W'(0)`: reset value of every register.
- `ZERO_REG`, 1: when 1, register 0 is hardwired to zero.
- `CNT_W`, `Util_Math_log2(ADDR_L)+1`: width of `pendCount`.

Ports:
- `ctrl`  input  `Data_Control_T`  clock and reset bundle. One clock. Reset is synchronous and active-low.
- `rdAddr`  input  `RD_PORTS*ADDR_W`  read addresses, port p at bits [p*ADDR_W +: ADDR_W].
- `rdData`  output  `RD_PORTS*DATA_W`  read data, same packing.
- `rdReady`  output  `RD_PORTS`  1 = `rdData[p]` is final (no outstanding producer).
- `wrAddr`  input  `WR_PORTS*ADDR_W`  write addresses.
- `wrData`  input  `WR_PORTS*DATA_W`  write data.
- `wrEnable`  input  `WR_PORTS`  per-port write strobe.
- `issAddr`  input  `ADDR_W`  destination register being issued.
- `issEnable`  input  1  issue request.
- `issStall`  output  1  issue refused this cycle.
- `pendCount`  output  `CNT_W`  number of registers currently pending.

## Operation
- **State.**
  - `regs[0:ADDR_L-1]`.
  - `pend[0:ADDR_L-1]`.
  - `pendCount` register.
- **Effective write port.** Port w is effective iff `wrEnable[w]` is set and not (`ZERO_REG` and `wrAddr[w]==0`).
- **Write priority.** When several effective ports target the same address, the highest index wins.
- **Read p, data.**
  - If `ZERO_REG` and the address is 0: `rdData=0`, `rdReady=1`.
  - Else if any effective write port matches: `rdData` = winning port's `wrData` (bypass), `rdReady=1`.
  - Else: `rdData=regs[addr]`, `rdReady=!pend[addr]`.
- **Issue stall.** `issStall = issEnable & pend[issAddr] & !(any effective write to issAddr)`.
  - A write landing in the same cycle resolves the WAW hazard.
- **Issue accept.** Accepted iff `issEnable & !issStall` and not (`ZERO_REG` and `issAddr==0`).
  - An issue to register 0 with `ZERO_REG` is accepted with no effect.
- **Next-state pending bits.** For each register r:
  - Accepted issue to r sets `pend[r]=1`. This takes precedence over a same-cycle write to r, because the new producer supersedes.
  - Otherwise any effective write to r clears `pend[r]`.
  - Otherwise `pend[r]` holds.
- **Count update.** `pendCount_next = pendCount + inc - dec`.
  - `inc` = 1 if an accepted issue targets a register not pending after its same-cycle writes are applied, else 0.
  - `dec` = number of distinct registers with `pend=1` that are cleared this cycle. Two ports writing the same register count once. Writes to non-pending registers count 0.
  - Invariant: `pendCount` equals popcount(`pend`). Never wraps.
- **Reset** (reset field low at a rising edge):
  - Every register is set to `RESET`.
  - `pend` is all 0 and `pendCount` is 0.
  - Writes and issues in that cycle are ignored.

## Timing
- Reads, `rdReady` and `issStall` are purely combinational from inputs and current state. Zero-cycle latency.
- Writes reach `regs` at the next rising edge. In the same cycle they are visible only through the bypass.
- `pend` and `pendCount` update at the rising edge after an issue or write.
- During reset, outputs follow the combinational rules against the pre-reset state until the edge. After the edge:
  - `rdData` = `RESET`, or 0 for register 0 when `ZERO_REG`.
  - `rdReady` is all 1.
  - `issStall` = 0.
  - `pendCount` = 0.
- Reset mid-operation discards every outstanding pending mark with no completion.

## Test plan
1. **Reset.** Assert reset for 1 cycle with `RESET=32'hDEADBEEF`, then read r5 and r0 → `rdData` = DEADBEEF and 0 respectively, `rdReady`=1, `pendCount`=0.
2. **Same-address write priority and bypass.** In one cycle, write port 0 drives r7 = 0x11 and port 1 drives r7 = 0x22 while read port 0 reads r7 → `rdData`=0x22 that cycle, and `regs[7]`=0x22 afterwards.
3. **RAW readiness.** Issue r9 → next cycle `rdReady` for r9 is 0 and `pendCount`=1. Then write r9 = 0x5A on port 0 while reading it → `rdData`=0x5A, `rdReady`=1. The next cycle `pendCount`=0.
4. **WAW stall.**
   - r3 pending, issue r3 with no write → `issStall`=1, `pendCount` unchanged.
   - Repeat with a same-cycle write to r3 → `issStall`=0, r3 stays pending, `pendCount` unchanged.
5. **Zero register.** Write 0xFF to r0 and issue r0 → r0 reads 0, `rdReady`=1, `pendCount` unchanged.
6. **Count and mid-operation reset.** Issue r1, r2, r4 over three cycles (`pendCount`=3). Write r1 on both ports in one cycle → `pendCount`=2. Then assert reset → `pendCount`=0 and all `rdReady`=1.
